rx_serial_7e2: RTL and testbench

Serial receiver for 7-bit ASCII characters framed as 7E2: one start bit, 7 data bits LSB first, even parity, two stop bits. It sits on the input side of the serial link, opposite the transmitter that drives `saida_serial`. It samples the line at mid-bit, delivers the character in parallel, and flags parity and framing errors. Upstream logic consumes characters through a `tem_dado`/`recebe` handshake.

---
 rtl/rx_serial_7e2_if.sv | 37 +++
 rtl/rx_serial_7e2.sv | 165 ++++++++++++++++
 tb/tb_rx_serial_7e2.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rx_serial_7e2_if.sv
// Signal bundle between the 7E2 receiver and its line/consumer side.
// "master" is the side driving the line and acknowledging; "slave" is the receiver.
interface rx_serial_7e2_if;
    // Handshake: tem_dado rises with the pronto pulse at the end of a frame and stays high
    // until the consumer holds recebe high for one clock edge. A frame ending on the
    // same edge as recebe keeps tem_dado high. A new frame overwrites the data silently.
    logic       dado_serial;
    logic       recebe;
    logic [6:0] dados_ascii;
    logic       paridade_ok;
    logic       erro_parada;
    logic       pronto;
    logic       tem_dado;
    logic [3:0] db_estado;

    modport master (
        output dado_serial,
        output recebe,
        input  dados_ascii,
        input  paridade_ok,
        input  erro_parada,
        input  pronto,
        input  tem_dado,
        input  db_estado
    );

    modport slave (
        input  dado_serial,
        input  recebe,
        output dados_ascii,
        output paridade_ok,
        output erro_parada,
        output pronto,
        output tem_dado,
        output db_estado
    );
endinterface

// File: rtl/rx_serial_7e2.sv
// 7E2 serial receiver: 2-flop synchronizer, mid-bit sampling FSM, registered parallel outputs.
// Macro RX_PARIDADE_EN enables the even-parity check; undefined, paridade_ok reads 1 after each frame.
module rx_serial_7e2 #(
    parameter int M = 434
) (
    input logic           clock,
    input logic           reset,
    rx_serial_7e2_if.slave bus
);

    localparam int TW = (M > 2) ? $clog2(M) : 2;
    localparam logic [TW-1:0] HALF_LAST = TW'(M / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(M - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] START    = 4'd1;
    localparam logic [3:0] DADOS    = 4'd2;
    localparam logic [3:0] PARIDADE = 4'd3;
    localparam logic [3:0] PARADA1  = 4'd4;
    localparam logic [3:0] PARADA2  = 4'd5;
    localparam logic [3:0] FIM      = 4'd6;

    logic          sync1;
    logic          s;
    logic          armed;
    logic [3:0]    state;
    logic [3:0]    next_state;
    logic [TW-1:0] tick;
    logic          tick_done;
    logic [2:0]    bit_cnt;
    logic [6:0]    shift;
    logic          stop_err;
    logic          leaving_idle;
`ifdef RX_PARIDADE_EN
    logic          parity_bit;
`endif

    logic [6:0]    dados_r;
    logic          paridade_r;
    logic          erro_r;
    logic          pronto_r;
    logic          tem_r;

    // Synchronizer resets low so a line held low across reset is never taken as a start;
    // armed then waits for a high level before the first falling edge is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync1 <= bus.dado_serial;
            s     <= sync1;
            armed <= armed | s;
        end
    end

    assign leaving_idle = (state == IDLE) && armed && !s;
    assign tick_done    = (state == START) ? (tick == HALF_LAST) : (tick == FULL_LAST);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (leaving_idle) next_state = START;
            START:    if (tick_done) next_state = s ? IDLE : DADOS;
            DADOS:    if (tick_done && bit_cnt == 3'd6) next_state = PARIDADE;
            PARIDADE: if (tick_done) next_state = PARADA1;
            PARADA1:  if (tick_done) next_state = PARADA2;
            PARADA2:  if (tick_done) next_state = FIM;
            FIM:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Tick counter starts from 0 on entry to START so the first sample lands at mid start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick <= '0;
        end else if (state == IDLE || state == FIM || tick_done) begin
            tick <= '0;
        end else begin
            tick <= tick + TICK_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt <= 3'd0;
        end else if (state == IDLE) begin
            bit_cnt <= 3'd0;
        end else if (state == DADOS && tick_done) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift    <= 7'd0;
            stop_err <= 1'b0;
        end else if (leaving_idle) begin
            shift    <= 7'd0;
            stop_err <= 1'b0;
        end else if (tick_done) begin
            if (state == DADOS) begin
                shift <= {s, shift[6:1]};
            end
            if ((state == PARADA1 || state == PARADA2) && !s) begin
                stop_err <= 1'b1;
            end
        end
    end

`ifdef RX_PARIDADE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_bit <= 1'b0;
        end else if (state == PARIDADE && tick_done) begin
            parity_bit <= s;
        end
    end
`endif

    // FIM takes priority over recebe so a freshly delivered character is never lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dados_r    <= 7'd0;
            paridade_r <= 1'b0;
            erro_r     <= 1'b0;
            pronto_r   <= 1'b0;
            tem_r      <= 1'b0;
        end else begin
            pronto_r <= 1'b0;
            if (state == FIM) begin
                dados_r    <= shift;
`ifdef RX_PARIDADE_EN
                paridade_r <= ~(^{shift, parity_bit});
`else
                paridade_r <= 1'b1;
`endif
                erro_r     <= stop_err;
                pronto_r   <= 1'b1;
                tem_r      <= 1'b1;
            end else if (bus.recebe) begin
                tem_r <= 1'b0;
            end
        end
    end

    assign bus.dados_ascii = dados_r;
    assign bus.paridade_ok = paridade_r;
    assign bus.erro_parada = erro_r;
    assign bus.pronto      = pronto_r;
    assign bus.tem_dado    = tem_r;
    assign bus.db_estado   = state;

endmodule

// File: tb/tb_rx_serial_7e2.sv
// Directed bench for rx_serial_7e2 at M = 8; expected parity result follows RX_PARIDADE_EN.
module tb_rx_serial_7e2;

    localparam int M = 8;

    logic clock;
    logic reset;
    int   cyc;
    int   e0;
    int   base;
    int   n_tests;
    int   n_fail;
    int   pronto_cnt;
    int   last_pronto_cyc;
    int   prev_pronto_cyc;
    logic exp_par_wrong;

    rx_serial_7e2_if bus();

    rx_serial_7e2 #(.M(M)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Clock and cycle counter
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge
    initial begin
        pronto_cnt      = 0;
        last_pronto_cyc = 0;
        prev_pronto_cyc = 0;
    end
    always @(negedge clock) begin
        if (bus.pronto === 1'b1) begin
            pronto_cnt      = pronto_cnt + 1;
            prev_pronto_cyc = last_pronto_cyc;
            last_pronto_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called right after a rising edge; returns right at the rising edge that ends stop 2.
    task automatic send_frame(input logic [6:0] d, input logic par, input logic st1, input logic st2);
        logic [10:0] bits;
        bits = {st2, st1, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            #1 bus.dado_serial = bits[i];
            if (i == 0) e0 = cyc + 1;
            repeat (M) @(posedge clock);
        end
    endtask

    task automatic pulse_recebe();
        @(posedge clock);
        #1 bus.recebe = 1'b1;
        @(posedge clock);
        #1 bus.recebe = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
`ifdef RX_PARIDADE_EN
        exp_par_wrong = 1'b0;
`else
        exp_par_wrong = 1'b1;
`endif
        reset           = 1'b1;
        bus.dado_serial = 1'b1;
        bus.recebe      = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(negedge clock);

        check("rst_dados",    bus.dados_ascii, 0);
        check("rst_paridade", bus.paridade_ok, 0);
        check("rst_erro",     bus.erro_parada, 0);
        check("rst_pronto",   bus.pronto, 0);
        check("rst_tem",      bus.tem_dado, 0);
        check("rst_estado",   bus.db_estado, 0);

        // 'A', correct parity
        base = pronto_cnt;
        @(posedge clock);
        send_frame(7'h41, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clock);
        check("a_pulses",   pronto_cnt - base, 1);
        check("a_time",     last_pronto_cyc, e0 + 87);
        check("a_dados",    bus.dados_ascii, 32'h41);
        check("a_paridade", bus.paridade_ok, 1);
        check("a_erro",     bus.erro_parada, 0);
        check("a_tem",      bus.tem_dado, 1);

        // 'C' with wrong parity bit
        base = pronto_cnt;
        @(posedge clock);
        send_frame(7'h43, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clock);
        check("c_pulses",   pronto_cnt - base, 1);
        check("c_dados",    bus.dados_ascii, 32'h43);
        check("c_paridade", bus.paridade_ok, {31'd0, exp_par_wrong});

        // Stop 1 low, then a clean frame clears the error
        @(posedge clock);
        send_frame(7'h41, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clock);
        check("stop_erro",  bus.erro_parada, 1);
        check("stop_dados", bus.dados_ascii, 32'h41);
        @(posedge clock);
        send_frame(7'h5A, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clock);
        check("z_erro",     bus.erro_parada, 0);
        check("z_dados",    bus.dados_ascii, 32'h5A);
        check("z_paridade", bus.paridade_ok, 1);

        // 3-cycle glitch on idle line
        base = pronto_cnt;
        @(posedge clock);
        #1 bus.dado_serial = 1'b0;
        e0 = cyc + 1;
        repeat (3) @(posedge clock);
        #1 bus.dado_serial = 1'b1;
        @(negedge clock);
        check("glitch_start", bus.db_estado, 1);
        repeat (5) @(negedge clock);
        check("glitch_when",  cyc, e0 + 7);
        check("glitch_idle",  bus.db_estado, 0);
        repeat (100) @(negedge clock);
        check("glitch_pulses", pronto_cnt - base, 0);
        check("glitch_dados",  bus.dados_ascii, 32'h5A);
        check("glitch_tem",    bus.tem_dado, 1);

        // Back-to-back frames after clearing tem_dado
        pulse_recebe();
        @(negedge clock);
        check("ack_tem", bus.tem_dado, 0);
        base = pronto_cnt;
        @(posedge clock);
        send_frame(7'h31, 1'b1, 1'b1, 1'b1);
        send_frame(7'h32, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clock);
        check("b2b_pulses",   pronto_cnt - base, 2);
        check("b2b_spacing",  last_pronto_cyc - prev_pronto_cyc, 88);
        check("b2b_dados",    bus.dados_ascii, 32'h32);
        check("b2b_paridade", bus.paridade_ok, 1);
        check("b2b_tem",      bus.tem_dado, 1);
        pulse_recebe();
        @(negedge clock);
        check("b2b_ack_tem", bus.tem_dado, 0);

        // Reset during the data bits, released during stop 1
        base = pronto_cnt;
        @(posedge clock);
        fork
            send_frame(7'h41, 1'b0, 1'b1, 1'b1);
            begin
                repeat (7 * M + 3) @(posedge clock);
                #1 check("mid_estado", bus.db_estado, 2);
                #1 reset = 1'b1;
                #1;
                check("mid_dados",    bus.dados_ascii, 0);
                check("mid_paridade", bus.paridade_ok, 0);
                check("mid_erro",     bus.erro_parada, 0);
                check("mid_pronto",   bus.pronto, 0);
                check("mid_tem",      bus.tem_dado, 0);
                check("mid_rst_est",  bus.db_estado, 0);
                repeat (2 * M + 1) @(posedge clock);
                #2 reset = 1'b0;
            end
        join
        repeat (40) @(negedge clock);
        check("mid_pulses", pronto_cnt - base, 0);
        check("mid_after",  bus.db_estado, 0);
        base = pronto_cnt;
        @(posedge clock);
        send_frame(7'h42, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clock);
        check("post_pulses",   pronto_cnt - base, 1);
        check("post_time",     last_pronto_cyc, e0 + 87);
        check("post_dados",    bus.dados_ascii, 32'h42);
        check("post_paridade", bus.paridade_ok, 1);
        check("post_erro",     bus.erro_parada, 0);
        check("post_tem",      bus.tem_dado, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
